// File: rtl/vec_add_n_top.sv
// ---------------------------------------------------------------------------
// vec_add_n_top
//   Self-contained N-element vector adder: z[i] = x[i] + y[i].
//   x and y are constant ROMs (x[i] = i, y[i] = 2*i + 1), z is an internal RAM.
//   A level 'start' sampled in IDLE launches a run of N write cycles; 'done'
//   pulses for one cycle on the edge that writes the last element. Results
//   are read through a registered random-access port that works in any state.
//
//   Optional feature (macro VEC_ADD_RUN_OFFSET_EN):
//     adds a DATA_W-bit run counter, reset to 0 and incremented whenever done
//     is raised; each run writes z[i] = x[i] + y[i] + run_count.
//
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       synchronous, active-high reset
//   start      in   1       level run request, sampled only in IDLE
//   done       out  1       one-cycle pulse when all N results are written
//   z_rd_addr  in   ADDR_W  result read address
//   z_dout     out  DATA_W  registered z[z_rd_addr], 1-cycle latency
// ---------------------------------------------------------------------------
module vec_add_n_top #(
  parameter int unsigned N      = 64,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] z_rd_addr,
  output logic [DATA_W-1:0] z_dout
);

  typedef enum logic {
    IDLE,
    COMPUTE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] z_dout_q;

  logic [DATA_W-1:0] x_rom [N];
  logic [DATA_W-1:0] y_rom [N];
  logic [DATA_W-1:0] z_mem [N];

  logic              z_we;
  logic [DATA_W-1:0] z_wdata;

`ifdef VEC_ADD_RUN_OFFSET_EN
  logic [DATA_W-1:0] run_count_q, run_count_d;
`endif

  // Constant ROM contents, fixed at elaboration.
  for (genvar gi = 0; gi < N; gi++) begin : g_rom
    assign x_rom[gi] = DATA_W'(gi);
    assign y_rom[gi] = DATA_W'(2 * gi + 1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    z_we    = 1'b0;
`ifdef VEC_ADD_RUN_OFFSET_EN
    z_wdata     = x_rom[idx_q] + y_rom[idx_q] + run_count_q;
    run_count_d = run_count_q;
`else
    z_wdata = x_rom[idx_q] + y_rom[idx_q];
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          idx_d   = '0;
        end
      end
      COMPUTE: begin
        z_we  = 1'b1;
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(N - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef VEC_ADD_RUN_OFFSET_EN
    if (done_d) begin
      run_count_d = run_count_q + DATA_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      z_dout_q <= '0;
`ifdef VEC_ADD_RUN_OFFSET_EN
      run_count_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      z_dout_q <= z_mem[z_rd_addr];
`ifdef VEC_ADD_RUN_OFFSET_EN
      run_count_q <= run_count_d;
`endif
    end
  end

  // Result RAM is never cleared; reset only suppresses the in-flight write so
  // an aborted run leaves earlier entries intact.
  always_ff @(posedge clk) begin
    if (z_we && !reset) begin
      z_mem[idx_q] <= z_wdata;
    end
  end

  assign done   = done_q;
  assign z_dout = z_dout_q;

endmodule

// File: tb/tb_vec_add_n_top.sv
module tb_vec_add_n_top;

  localparam int unsigned N      = 64;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] z_rd_addr;
  logic [DATA_W-1:0] z_dout;

  vec_add_n_top #(
    .N      (N),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .z_rd_addr (z_rd_addr),
    .z_dout    (z_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb_q[$];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[6];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Offset a run adds to every element; zero unless the run counter exists.
  function automatic logic [DATA_W-1:0] run_ofs(input int run_index);
`ifdef VEC_ADD_RUN_OFFSET_EN
    return DATA_W'(run_index);
`else
    return '0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_zdout", z_dout, 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      step();
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Scoreboard read: expectation queued when address is driven, popped when
  // the registered output is available one cycle later.
  task automatic rd(input string nm, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    z_rd_addr = a;
    sb_q.push_back(e);
    step();
    chk(nm, z_dout, sb_q.pop_front());
  endtask

  int cyc;
  int pulses;
  int last;
  int first;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr: 6'd0,  exp: 32'd1};
    vecs[1] = '{addr: 6'd5,  exp: 32'd16};
    vecs[2] = '{addr: 6'd63, exp: 32'd190};
    vecs[3] = '{addr: 6'd1,  exp: 32'd4};
    vecs[4] = '{addr: 6'd31, exp: 32'd94};
    vecs[5] = '{addr: 6'd62, exp: 32'd187};

    reset     = 1'b1;
    start     = 1'b0;
    z_rd_addr = '0;

    // 1. single run
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, cyc);
    chk("single_latency", cyc, 64);
    step();
    chk("single_done_width", {31'b0, done}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      rd("single_rd", vecs[i].addr, vecs[i].exp + run_ofs(0));
    end

    // 2. held start: five pulses, period N+1
    do_reset();
    start  = 1'b1;
    pulses = 0;
    last   = 0;
    first  = -1;
    for (int k = 1; k <= 5 * 65 + 1; k++) begin
      step();
      if (done) begin
        pulses++;
        if (pulses == 1) first = k;
        else chk("held_period", k - last, 65);
        last = k;
        if (pulses == 5) begin
          start = 1'b0;
          break;
        end
      end
    end
    chk("held_pulses", pulses, 5);
    chk("held_first", first, 65);
    rd("held_z63", 6'd63, 32'd190 + run_ofs(4));

    // 3. full read sweep, back-to-back addresses
    for (int a = 0; a < 64; a++) begin
      rd("sweep", ADDR_W'(a), DATA_W'(3 * a + 1) + run_ofs(4));
    end

    // 4. start toggled mid-run is ignored
    do_reset();
    start = 1'b1;
    step();
    start  = 1'b0;
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k == 10) start = 1'b1;
      if (k == 20) start = 1'b0;
      if (k == 30) start = 1'b1;
      if (k == 40) start = 1'b0;
      step();
      if (done) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("midstart_pulses", pulses, 1);
    chk("midstart_latency", first, 64);

    // 5. reset at edge 30 aborts the run
    do_reset();
    start = 1'b1;
    step();
    start  = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (done) pulses++;
    end
    reset = 1'b1;
    step();
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_zdout", z_dout, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    for (int a = 0; a <= 28; a++) begin
      rd("abort_kept", ADDR_W'(a), DATA_W'(3 * a + 1));
    end
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, cyc);
    chk("restart_latency", cyc, 64);
    rd("restart_z63", 6'd63, 32'd190 + run_ofs(0));

    // 6. idle hold
    do_reset();
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (done) pulses++;
    end
    chk("idle_no_done", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_add_n_top.md
Name: vec_add_n_top

Overview:
- Self-contained N-element vector adder: z[i] = x[i] + y[i] for i = 0..N-1.
- x and y are internal constant ROMs; z is an internal RAM.
- Host-side control logic starts it with a level start, waits for a single-cycle done pulse, then reads results through a registered random-access read port.
- Sits under the AFU control state machine as its compute kernel.

Parameters:
- N, 64, number of vector elements; must equal 2**ADDR_W.
- DATA_W, 32, element width in bits.
- ADDR_W, 6, index/read-address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request to run; sampled only in IDLE.
- done  out  1  one-cycle pulse when all N results are written.
- z_rd_addr  in  ADDR_W  result read address.
- z_dout  out  DATA_W  registered z[z_rd_addr].

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- ROM contents (fixed at elaboration):
  - x[i] = i.
  - y[i] = 2*i + 1.
  - Resulting z[i] = 3*i + 1.
- Arithmetic: DATA_W-bit unsigned add, wraps modulo 2**DATA_W, no carry out.
- State machine has two states, IDLE and COMPUTE, plus an internal ADDR_W-bit index idx.
- IDLE:
  - If start=1 at a rising edge: go to COMPUTE, idx<=0.
  - Otherwise stay in IDLE.
- COMPUTE: each edge writes z[idx] <= x[idx] + y[idx] and increments idx.
  - On the edge that writes idx = N-1: done<=1, state<=IDLE.
- Timing: call the start-accepting edge edge 0.
  - z[i] is written at edge i+1.
  - done is high from edge N to edge N+1, exactly one cycle.
  - done defaults to 0 on every other edge.
- Restart: if start is still high at edge N (back in IDLE), a new run begins there. With start held high, done pulses every N+1 cycles (65 for defaults).
- start changes during COMPUTE are ignored; a run always completes once started.
- Read port:
  - z_dout <= z[z_rd_addr] every edge, 1-cycle latency, in any state.
  - Reading the address being written on the same edge returns the old value.
- Reset values:
  - state = IDLE, idx = 0, done = 0, z_dout = 0.
  - z RAM is not cleared; contents are undefined until written by a run.
- Reset mid-COMPUTE: abort immediately, no done pulse. Already-written z entries keep their values.

Optional Feature:
- Macro: VEC_ADD_RUN_OFFSET_EN.
- Defined:
  - Adds a DATA_W-bit run counter, reset to 0, incremented on each edge where done is set to 1.
  - Writes become z[i] = x[i] + y[i] + run_count (wrapping), using the counter value held during that run.
  - Back-to-back runs produce distinguishable results.
- Undefined: no counter; z[i] = x[i] + y[i].

Test Plan:
1. Single run: reset 2 cycles, start=1 for one cycle, then 0 -> done high exactly one cycle, N=64 edges after acceptance. Reading addr 0, 5, 63 (1-cycle latency) gives 1, 16, 190.
2. Held start: start=1 continuously -> done pulses with period 65 cycles. Five pulses seen within 5*65+1 cycles. Without the macro z[63]=190 after every run. With VEC_ADD_RUN_OFFSET_EN, z[63]=194 after the 5th run.
3. Read latency: sweep z_rd_addr 0..63, one per cycle, after a run -> z_dout on the next cycle equals 3*addr+1. z_dout is 0 before the first read after reset.
4. start during COMPUTE: pulse start low/high mid-run -> no extra done, and done timing is unchanged.
5. Reset mid-run: assert reset at edge 30 -> no done pulse, done=0 and z_dout=0. z[0..28] equal 3i+1. A new start then completes normally.
6. Idle hold: start=0 for 200 cycles after reset -> done stays 0 throughout.
